// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns a single-cycle core load/store into a
// request/acknowledge memory transaction with byte lanes, sign/zero
// extension, misalignment detection and a bounded wait for mem_ack.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_valid,
    input  logic        core_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last BUSY cycle index before the wait is abandoned.
    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    // Access legality: size code must exist for the direction, and
    // halfwords/words must be naturally aligned.
    function automatic logic f_legal(input logic we, input logic [2:0] f3,
                                     input logic [1:0] lo);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = (lo[0] == 1'b0);
            3'b010:  ok = (lo == 2'b00);
            3'b100:  ok = !we;
            3'b101:  ok = !we && (lo[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables; the size is carried in the low two bits of funct3.
    function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = 4'b0011 << lo;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate store data across every lane it could land in.
    function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            2'b10:   w = d;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Pick the addressed lane out of the read word and extend it.
    function automatic logic [31:0] f_extract(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*lo +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'h00_0000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lo_q, lo_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        legal_s;
    logic        timeout_hit_s;

    // Classify the incoming access and detect the final unacknowledged wait cycle.
    always_comb begin
        legal_s       = f_legal(core_we, funct3, addr[1:0]);
        timeout_hit_s = (state_q == BUSY) && !mem_ack && (cnt_q == CNT_LAST);
    end

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (core_valid && legal_s) begin
                    state_d     = BUSY;
                    we_d        = core_we;
                    f3_d        = funct3;
                    lo_d        = addr[1:0];
                    cnt_d       = 10'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = core_we;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_be_d    = f_be(funct3[1:0], addr[1:0]);
                    mem_wdata_d = f_wdata(funct3[1:0], wdata);
                end else begin
                    rdata_d = 32'h0000_0000;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d   = DONE;
                    rdata_d   = we_q ? 32'h0000_0000 : f_extract(f3_q, lo_q, mem_rdata);
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'b0000;
                end else if (timeout_hit_s) begin
                    state_d   = IDLE;
                    rdata_d   = 32'h0000_0000;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'b0000;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                rdata_d = 32'h0000_0000;
            end
            default: begin
                state_d   = IDLE;
                rdata_d   = 32'h0000_0000;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                mem_be_d  = 4'b0000;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            lo_q        <= 2'b00;
            cnt_q       <= 10'd0;
            rdata_q     <= 32'h0000_0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Core handshake: stall while accepting or waiting, err on illegal access or abort.
    always_comb begin
        if (reset) begin
            stall = 1'b0;
            err   = 1'b0;
        end else begin
            stall = ((state_q == IDLE) && core_valid && legal_s) ||
                    ((state_q == BUSY) && !timeout_hit_s);
            err   = ((state_q == IDLE) && core_valid && !legal_s) || timeout_hit_s;
        end
    end

    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
